// File: rtl/vend_pkg.sv
// Shared types and constants for the newspaper vending sequencer and the vending FSM.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2,
    FAULT    = 2'd3
  } state_t;

  // Coin codes exchanged with the vending FSM.
  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10
  } coin_t;

  localparam int PRICE       = 15;
  localparam int CHANGE_UNIT = 5;

endpackage

// File: rtl/vend_timeout_timer.sv
// Drive watchdog: counts cycles while enabled; expired flags the last allowed cycle without a done.
module vend_timeout_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int               CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable && (cnt_reg != LAST)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign expired = enable && (cnt_reg == LAST);

endmodule

// File: rtl/vend_dispense_sequencer.sv
// Queues paper/change requests and runs motor then hopper with done handshakes, timeouts and stock tracking.
// Optional audit counter on vend_total is built when VEND_AUDIT_EN is defined.
module vend_dispense_sequencer
  import vend_pkg::*;
#(
  parameter int STOCK_INIT  = 50,
  parameter int STOCK_W     = 8,
  parameter int PEND_MAX    = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vend_req,
  input  logic               change_req,
  output logic               motor_on,
  input  logic               motor_done,
  output logic               hopper_on,
  input  logic               hopper_done,
  input  logic               refill,
  input  logic               fault_clr,
  output logic [STOCK_W-1:0] stock_cnt,
  output logic               coin_inhibit,
  output logic               busy,
  output logic               fault,
  output logic               drop_err,
  output logic [15:0]        vend_total
);

  localparam int                 PEND_W     = $clog2(PEND_MAX + 1);
  localparam logic [PEND_W-1:0]  PEND_FULL  = PEND_W'(PEND_MAX);
  localparam logic [STOCK_W-1:0] STOCK_LOAD = STOCK_W'(STOCK_INIT);

  state_t             state_reg, state_next;
  logic [PEND_W-1:0]  pend_reg, pend_next;
  logic [PEND_W-1:0]  chg_reg, chg_next;
  logic [STOCK_W-1:0] stock_reg, stock_next, stock_eff;
  logic               motor_on_reg, hopper_on_reg, fault_reg;
  logic               coin_inhibit_reg, busy_reg, drop_err_reg;
  logic               coin_inhibit_next, busy_next, drop_next;
  logic               refill_ok, vend_acc, chg_acc, vend_done, chg_done;
  logic               tmr_clear, tmr_enable, tmr_expired;

  vend_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

  // Any state change restarts the watchdog, so each drive phase gets a full window.
  assign tmr_clear  = (state_next != state_reg);
  assign tmr_enable = (state_reg == DISPENSE) || (state_reg == CHANGE);

  always_comb begin
    refill_ok = refill && ((state_reg == IDLE) || (state_reg == FAULT));
    stock_eff = refill_ok ? STOCK_LOAD : stock_reg;
    vend_acc  = vend_req && (pend_reg < PEND_FULL) && (STOCK_W'(pend_reg) < stock_eff);
    chg_acc   = change_req && (chg_reg < PEND_FULL);
    vend_done = (state_reg == DISPENSE) && motor_done;
    chg_done  = (state_reg == CHANGE) && hopper_done;

    pend_next = pend_reg;
    if (vend_acc && !vend_done) begin
      pend_next = pend_reg + PEND_W'(1);
    end else if (!vend_acc && vend_done) begin
      pend_next = pend_reg - PEND_W'(1);
    end

    chg_next = chg_reg;
    if (chg_acc && !chg_done) begin
      chg_next = chg_reg + PEND_W'(1);
    end else if (!chg_acc && chg_done) begin
      chg_next = chg_reg - PEND_W'(1);
    end

    stock_next = stock_eff;
    if (vend_done && (stock_reg != '0)) begin
      stock_next = stock_reg - STOCK_W'(1);
    end
  end

  // Paper always goes before change; a done on the same cycle as expiry still completes.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (pend_reg != '0) begin
          state_next = DISPENSE;
        end else if (chg_reg != '0) begin
          state_next = CHANGE;
        end
      end
      DISPENSE: begin
        if (motor_done) begin
          state_next = (chg_reg != '0) ? CHANGE : IDLE;
        end else if (tmr_expired) begin
          state_next = FAULT;
        end
      end
      CHANGE: begin
        if (hopper_done) begin
          state_next = IDLE;
        end else if (tmr_expired) begin
          state_next = FAULT;
        end
      end
      FAULT: begin
        if (fault_clr) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    drop_next         = (vend_req && !vend_acc) || (change_req && !chg_acc);
    coin_inhibit_next = (state_next == FAULT) || (pend_next == PEND_FULL) ||
                        (chg_next == PEND_FULL) || (STOCK_W'(pend_next) >= stock_next);
    busy_next         = (state_next != IDLE) || (pend_next != '0) || (chg_next != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      pend_reg         <= '0;
      chg_reg          <= '0;
      stock_reg        <= STOCK_LOAD;
      motor_on_reg     <= 1'b0;
      hopper_on_reg    <= 1'b0;
      fault_reg        <= 1'b0;
      coin_inhibit_reg <= 1'b0;
      busy_reg         <= 1'b0;
      drop_err_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      pend_reg         <= pend_next;
      chg_reg          <= chg_next;
      stock_reg        <= stock_next;
      motor_on_reg     <= (state_next == DISPENSE);
      hopper_on_reg    <= (state_next == CHANGE);
      fault_reg        <= (state_next == FAULT);
      coin_inhibit_reg <= coin_inhibit_next;
      busy_reg         <= busy_next;
      drop_err_reg     <= drop_next;
    end
  end

  assign motor_on     = motor_on_reg;
  assign hopper_on    = hopper_on_reg;
  assign fault        = fault_reg;
  assign coin_inhibit = coin_inhibit_reg;
  assign busy         = busy_reg;
  assign drop_err     = drop_err_reg;
  assign stock_cnt    = stock_reg;

`ifdef VEND_AUDIT_EN
  logic [15:0] vend_total_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vend_total_reg <= 16'h0000;
    end else if (vend_done && (vend_total_reg != 16'hFFFF)) begin
      vend_total_reg <= vend_total_reg + 16'h0001;
    end
  end

  assign vend_total = vend_total_reg;
`else
  assign vend_total = 16'h0000;
`endif

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Directed bench: drive starts are checked against a queue of expected paper/change events.
module tb_vend_dispense_sequencer;

  localparam int STOCK_INIT  = 5;
  localparam int STOCK_W     = 8;
  localparam int PEND_MAX    = 3;
  localparam int TIMEOUT_CYC = 20;
  localparam int DONE_DLY    = 5;
  localparam int EV_PAPER    = 0;
  localparam int EV_COIN     = 1;
`ifdef VEND_AUDIT_EN
  localparam bit AUDIT = 1'b1;
`else
  localparam bit AUDIT = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               vend_req = 1'b0;
  logic               change_req = 1'b0;
  logic               motor_done = 1'b0;
  logic               hopper_done = 1'b0;
  logic               refill = 1'b0;
  logic               fault_clr = 1'b0;
  logic               motor_on, hopper_on, coin_inhibit, busy, fault, drop_err;
  logic [STOCK_W-1:0] stock_cnt;
  logic [15:0]        vend_total;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int exp_total = 0;
  bit auto_motor = 1'b1;
  bit auto_hop = 1'b1;

  always #5 clk = ~clk;

  vend_dispense_sequencer #(
    .STOCK_INIT (STOCK_INIT),
    .STOCK_W    (STOCK_W),
    .PEND_MAX   (PEND_MAX),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vend_req    (vend_req),
    .change_req  (change_req),
    .motor_on    (motor_on),
    .motor_done  (motor_done),
    .hopper_on   (hopper_on),
    .hopper_done (hopper_done),
    .refill      (refill),
    .fault_clr   (fault_clr),
    .stock_cnt   (stock_cnt),
    .coin_inhibit(coin_inhibit),
    .busy        (busy),
    .fault       (fault),
    .drop_err    (drop_err),
    .vend_total  (vend_total)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One-cycle pulse on the selected inputs, launched and retired on falling edges.
  task automatic drive(input bit v, input bit c, input bit r, input bit f);
    vend_req   = v;
    change_req = c;
    refill     = r;
    fault_clr  = f;
    @(negedge clk);
    vend_req   = 1'b0;
    change_req = 1'b0;
    refill     = 1'b0;
    fault_clr  = 1'b0;
    $display("drive vend=%0d change=%0d refill=%0d fault_clr=%0d stock=%0d busy=%0d",
             v, c, r, f, stock_cnt, busy);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_motor(input string tag);
    for (int i = 0; (i < 50) && (motor_on !== 1'b1); i++) @(negedge clk);
    chk(tag, 32'(motor_on), 32'd1);
  endtask

  // Mechanics model: done rises DONE_DLY cycles into a drive and falls once the drive drops.
  initial begin
    int mc;
    int hc;
    mc = 0;
    hc = 0;
    forever begin
      @(negedge clk);
      if (motor_on !== 1'b1) begin
        mc = 0;
        motor_done = 1'b0;
      end else begin
        mc++;
        if (auto_motor && (mc >= DONE_DLY)) motor_done = 1'b1;
      end
      if (hopper_on !== 1'b1) begin
        hc = 0;
        hopper_done = 1'b0;
      end else begin
        hc++;
        if (auto_hop && (hc >= DONE_DLY)) hopper_done = 1'b1;
      end
    end
  end

  // Each drive start must match the oldest expected event.
  initial begin
    logic prev_m;
    logic prev_h;
    int   want;
    prev_m = 1'b0;
    prev_h = 1'b0;
    forever begin
      @(negedge clk);
      if ((motor_on === 1'b1) && !prev_m) begin
        want = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        chk("seq_paper", 32'(EV_PAPER), 32'(want));
        $display("event paper start, expected code %0d", want);
      end
      if ((hopper_on === 1'b1) && !prev_h) begin
        want = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        chk("seq_change", 32'(EV_COIN), 32'(want));
        $display("event change start, expected code %0d", want);
      end
      prev_m = motor_on;
      prev_h = hopper_on;
    end
  end

  initial begin
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_motor", 32'(motor_on), 32'd0);
    chk("rst_stock", 32'(stock_cnt), 32'(STOCK_INIT));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_inhibit", 32'(coin_inhibit), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_total", 32'(vend_total), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single vend: drive appears two cycles after the request
    exp_q.push_back(EV_PAPER);
    drive(1, 0, 0, 0);
    chk("t1_motor_n1", 32'(motor_on), 32'd0);
    chk("t1_busy_n1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_motor_n2", 32'(motor_on), 32'd1);
    wait_idle("t1_idle");
    exp_total++;
    chk("t1_motor_off", 32'(motor_on), 32'd0);
    chk("t1_stock", 32'(stock_cnt), 32'(STOCK_INIT - 1));

    // Paper and change together: paper first
    exp_q.push_back(EV_PAPER);
    exp_q.push_back(EV_COIN);
    drive(1, 1, 0, 0);
    wait_idle("t2_idle");
    exp_total++;
    chk("t2_stock", 32'(stock_cnt), 32'(STOCK_INIT - 2));
    chk("t2_hopper_off", 32'(hopper_on), 32'd0);

    // Queue full on paper
    drive(0, 0, 1, 0);
    chk("t3_refill", 32'(stock_cnt), 32'(STOCK_INIT));
    auto_motor = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(EV_PAPER);
      drive(1, 0, 0, 0);
    end
    drive(1, 0, 0, 0);
    chk("t3_drop", 32'(drop_err), 32'd1);
    chk("t3_inhibit", 32'(coin_inhibit), 32'd1);
    @(negedge clk);
    chk("t3_drop_pulse", 32'(drop_err), 32'd0);
    auto_motor = 1'b1;
    wait_idle("t3_idle");
    exp_total += 3;
    chk("t3_stock", 32'(stock_cnt), 32'(STOCK_INIT - 3));
    chk("t3_inhibit_off", 32'(coin_inhibit), 32'd0);

    // Motor timeout; refill ignored while dispensing
    auto_motor = 1'b0;
    exp_q.push_back(EV_PAPER);
    drive(1, 0, 0, 0);
    wait_motor("t4_motor_on");
    drive(0, 0, 1, 0);
    chk("t4_refill_ignored", 32'(stock_cnt), 32'(STOCK_INIT - 3));
    repeat (TIMEOUT_CYC - 2) @(negedge clk);
    chk("t4_motor_last", 32'(motor_on), 32'd1);
    chk("t4_fault_early", 32'(fault), 32'd0);
    @(negedge clk);
    chk("t4_fault", 32'(fault), 32'd1);
    chk("t4_motor_cut", 32'(motor_on), 32'd0);
    chk("t4_stock_kept", 32'(stock_cnt), 32'(STOCK_INIT - 3));
    chk("t4_inhibit", 32'(coin_inhibit), 32'd1);
    auto_motor = 1'b1;
    exp_q.push_back(EV_PAPER);
    drive(0, 0, 0, 1);
    wait_idle("t4_idle");
    exp_total++;
    chk("t4_fault_clr", 32'(fault), 32'd0);
    chk("t4_stock", 32'(stock_cnt), 32'(STOCK_INIT - 4));

    // Stock out, then refill together with a vend
    exp_q.push_back(EV_PAPER);
    drive(1, 0, 0, 0);
    wait_idle("t5_idle_a");
    exp_total++;
    chk("t5_stock_zero", 32'(stock_cnt), 32'd0);
    chk("t5_inhibit", 32'(coin_inhibit), 32'd1);
    drive(1, 0, 0, 0);
    chk("t5_drop", 32'(drop_err), 32'd1);
    chk("t5_not_queued", 32'(busy), 32'd0);
    exp_q.push_back(EV_PAPER);
    drive(1, 0, 1, 0);
    chk("t5_refill", 32'(stock_cnt), 32'(STOCK_INIT));
    chk("t5_inhibit_off", 32'(coin_inhibit), 32'd0);
    wait_idle("t5_idle_b");
    exp_total++;
    chk("t5_stock", 32'(stock_cnt), 32'(STOCK_INIT - 1));

    // Change queue full, then reset in the middle of the hopper drive
    auto_hop = 1'b0;
    exp_q.push_back(EV_COIN);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0);
    chk("t6_drop", 32'(drop_err), 32'd1);
    chk("t6_inhibit", 32'(coin_inhibit), 32'd1);
    chk("t6_hopper", 32'(hopper_on), 32'd1);
    chk("t6_total", 32'(vend_total), AUDIT ? 32'(exp_total) : 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("t6_hopper_cut", 32'(hopper_on), 32'd0);
    chk("t6_stock", 32'(stock_cnt), 32'(STOCK_INIT));
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_inhibit_rst", 32'(coin_inhibit), 32'd0);
    chk("t6_drop_rst", 32'(drop_err), 32'd0);
    chk("t6_total_rst", 32'(vend_total), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    auto_hop = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_stay_idle", 32'(busy), 32'd0);
    chk("t6_no_hopper", 32'(hopper_on), 32'd0);
    chk("end_queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
